// File: rtl/dsqw_reg_blk_if.sv
`default_nettype none
// ============================================================================
// Module   : dsqw_reg_blk_if
// Brief    : APB3 bus bundle for the deskew register block.
// Revision : 1.0 - initial release
// ============================================================================
interface dsqw_reg_blk_if #(
    parameter int ADDR_W = 8
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface
`default_nettype wire

// File: rtl/dsqw_reg_blk.sv
`default_nettype none
// ============================================================================
// Module   : dsqw_reg_blk
// Brief    : APB3 register block for the deskew core: config, command pulses,
//            status with W1C acks and a saturating completed-job counter.
// Revision : 1.0 - initial release
// ============================================================================
module dsqw_reg_blk #(
    parameter int         ADDR_W  = 8,
    parameter logic [8:0] DIM_RST = 9'd0,
    parameter int         CNT_W   = 16
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    dsqw_reg_blk_if.slave apb,
    output logic [8:0]    img_dim,
    output logic [16:0]   in_img_start_addr,
    output logic [16:0]   out_img_start_addr,
    output logic          start_dsqw,
    output logic          soft_rst,
    output logic          dsqw_done_ack,
    output logic          err_size_ack,
    output logic          mem_acc_err_ack,
    input  wire logic     dsqw_idle,
    input  wire logic     dsqw_done,
    input  wire logic     err_size,
    input  wire logic     mem_acc_err
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    localparam logic [2:0] c_IDX_CTRL   = 3'd0;
    localparam logic [2:0] c_IDX_STATUS = 3'd1;
    localparam logic [2:0] c_IDX_DIM    = 3'd2;
    localparam logic [2:0] c_IDX_IN     = 3'd3;
    localparam logic [2:0] c_IDX_OUT    = 3'd4;
    localparam logic [2:0] c_IDX_JOB    = 3'd5;

    localparam logic [ADDR_W-1:0] c_MAX_ADDR = ADDR_W'(20);

    logic [1:0]       r_state;
    logic [2:0]       r_idx;
    logic [16:0]      r_wdata;
    logic             r_write;
    logic             r_err;
    logic [31:0]      r_rdata;
    logic [3:0]       r_status;
    logic             r_done_q;
    logic [CNT_W-1:0] r_job_cnt;
    logic [8:0]       r_img_dim;
    logic [16:0]      r_in_addr;
    logic [16:0]      r_out_addr;
    logic             r_start;
    logic             r_soft;
    logic             r_done_ack;
    logic             r_size_ack;
    logic             r_mem_ack;

    logic             w_access;
    logic [2:0]       w_idx;
    logic             w_err;
    logic [31:0]      w_rdata;
    logic             w_commit;
    logic             w_wr_ok;
    logic             w_rise;

    // Decode happens in the access cycle; the response is presented one cycle later.
    always_comb begin
        w_access = (r_state == c_ST_IDLE) && apb.psel && apb.penable;
        w_idx    = apb.paddr[4:2];
        w_err    = (apb.paddr[1:0] != 2'b00) || (apb.paddr > c_MAX_ADDR);
        if (apb.pwrite && !r_status[0]) begin
            case (w_idx)
                c_IDX_DIM, c_IDX_IN, c_IDX_OUT: w_err = 1'b1;
                c_IDX_CTRL: if (apb.pwdata[0] && !apb.pwdata[1]) w_err = 1'b1;
                default: begin end
            endcase
        end
        case (w_idx)
            c_IDX_STATUS: w_rdata = {28'd0, r_status};
            c_IDX_DIM:    w_rdata = {23'd0, r_img_dim};
            c_IDX_IN:     w_rdata = {15'd0, r_in_addr};
            c_IDX_OUT:    w_rdata = {15'd0, r_out_addr};
            c_IDX_JOB:    w_rdata = 32'(r_job_cnt);
            default:      w_rdata = 32'd0;
        endcase
        if (apb.pwrite || w_err) w_rdata = 32'd0;
        w_commit = (r_state == c_ST_WAIT) && apb.psel;
        w_wr_ok  = w_commit && r_write && !r_err;
        w_rise   = dsqw_done && !r_done_q;
    end

    assign apb.pready  = w_commit;
    assign apb.prdata  = w_commit ? r_rdata : 32'd0;
    assign apb.pslverr = w_commit && r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_idx   <= 3'd0;
            r_wdata <= 17'd0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_access) begin
                        r_state <= c_ST_WAIT;
                        r_idx   <= w_idx;
                        r_wdata <= apb.pwdata[16:0];
                        r_write <= apb.pwrite;
                        r_err   <= w_err;
                        r_rdata <= w_rdata;
                    end
                end
                // Losing psel here abandons the transfer without any side effect.
                c_ST_WAIT: r_state <= apb.psel ? c_ST_RESP : c_ST_IDLE;
                default:   r_state <= c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_img_dim  <= DIM_RST;
            r_in_addr  <= 17'd0;
            r_out_addr <= 17'd0;
            r_start    <= 1'b0;
            r_soft     <= 1'b0;
            r_done_ack <= 1'b0;
            r_size_ack <= 1'b0;
            r_mem_ack  <= 1'b0;
        end else begin
            // SOFT_RST wins over START when both are written together.
            r_start    <= w_wr_ok && (r_idx == c_IDX_CTRL) && r_wdata[0] && !r_wdata[1];
            r_soft     <= w_wr_ok && (r_idx == c_IDX_CTRL) && r_wdata[1];
            r_done_ack <= w_wr_ok && (r_idx == c_IDX_STATUS) && r_wdata[1];
            r_size_ack <= w_wr_ok && (r_idx == c_IDX_STATUS) && r_wdata[2];
            r_mem_ack  <= w_wr_ok && (r_idx == c_IDX_STATUS) && r_wdata[3];
            if (w_wr_ok && (r_idx == c_IDX_DIM)) r_img_dim  <= r_wdata[8:0];
            if (w_wr_ok && (r_idx == c_IDX_IN))  r_in_addr  <= r_wdata;
            if (w_wr_ok && (r_idx == c_IDX_OUT)) r_out_addr <= r_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_status  <= 4'd0;
            r_done_q  <= 1'b0;
            r_job_cnt <= '0;
        end else begin
            r_status <= {mem_acc_err, err_size, dsqw_done, dsqw_idle};
            r_done_q <= dsqw_done;
            if (w_wr_ok && (r_idx == c_IDX_JOB)) begin
                r_job_cnt <= w_rise ? CNT_W'(1) : '0;
            end else if (w_rise && (r_job_cnt != {CNT_W{1'b1}})) begin
                r_job_cnt <= r_job_cnt + CNT_W'(1);
            end
        end
    end

    assign img_dim            = r_img_dim;
    assign in_img_start_addr  = r_in_addr;
    assign out_img_start_addr = r_out_addr;
    assign start_dsqw         = r_start;
    assign soft_rst           = r_soft;
    assign dsqw_done_ack      = r_done_ack;
    assign err_size_ack       = r_size_ack;
    assign mem_acc_err_ack    = r_mem_ack;

endmodule
`default_nettype wire

// File: tb/tb_dsqw_reg_blk.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsqw_reg_blk
// Brief    : Self-checking bench for dsqw_reg_blk (two instances, CNT_W 16/2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dsqw_reg_blk;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [7:0]  paddr = 8'd0;
    logic [31:0] pwdata = 32'd0;
    logic        dsqw_idle = 1'b1, dsqw_done = 1'b0, err_size = 1'b0, mem_acc_err = 1'b0;

    always #5 clk = ~clk;

    dsqw_reg_blk_if #(.ADDR_W(8)) apb_a ();
    dsqw_reg_blk_if #(.ADDR_W(8)) apb_b ();

    assign apb_a.psel = psel;   assign apb_a.penable = penable; assign apb_a.pwrite = pwrite;
    assign apb_a.paddr = paddr; assign apb_a.pwdata = pwdata;
    assign apb_b.psel = psel;   assign apb_b.penable = penable; assign apb_b.pwrite = pwrite;
    assign apb_b.paddr = paddr; assign apb_b.pwdata = pwdata;

    logic [8:0]  dim_a, dim_b;
    logic [16:0] in_a, in_b, out_a, out_b;
    logic        st_a, sr_a, da_a, ea_a, ma_a, st_b, sr_b, da_b, ea_b, ma_b;
    logic [4:0]  pul_a, pul_b;
    assign pul_a = {st_a, sr_a, da_a, ea_a, ma_a};
    assign pul_b = {st_b, sr_b, da_b, ea_b, ma_b};

    dsqw_reg_blk #(.ADDR_W(8), .DIM_RST(9'd0), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .apb(apb_a.slave),
        .img_dim(dim_a), .in_img_start_addr(in_a), .out_img_start_addr(out_a),
        .start_dsqw(st_a), .soft_rst(sr_a), .dsqw_done_ack(da_a),
        .err_size_ack(ea_a), .mem_acc_err_ack(ma_a),
        .dsqw_idle(dsqw_idle), .dsqw_done(dsqw_done), .err_size(err_size), .mem_acc_err(mem_acc_err)
    );

    dsqw_reg_blk #(.ADDR_W(8), .DIM_RST(9'h0A5), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .apb(apb_b.slave),
        .img_dim(dim_b), .in_img_start_addr(in_b), .out_img_start_addr(out_b),
        .start_dsqw(st_b), .soft_rst(sr_b), .dsqw_done_ack(da_b),
        .err_size_ack(ea_b), .mem_acc_err_ack(ma_b),
        .dsqw_idle(dsqw_idle), .dsqw_done(dsqw_done), .err_size(err_size), .mem_acc_err(mem_acc_err)
    );

    // Reference model state: register contents and counters per instance.
    logic [8:0]  c_dim_rst [2] = '{9'd0, 9'h0A5};
    int          c_cnt_max [2] = '{65535, 3};
    logic [8:0]  m_dim [2] = '{9'd0, 9'h0A5};
    logic [16:0] m_in = 17'd0, m_out = 17'd0;
    int          m_cnt [2] = '{0, 0};
    bit          prev_done = 1'b0;

    bit          pend_valid = 1'b0;
    int          pend_idx = 0;
    logic [31:0] pend_d = 32'd0;

    logic        exp_pready = 1'b0, exp_pslverr = 1'b0;
    logic [31:0] exp_prdata [2] = '{32'd0, 32'd0};
    logic [4:0]  exp_pulse = 5'd0;

    logic [31:0] cap_a, cap_b;
    logic        cap_err, cap_rdy;
    int          n_cmp = 0, n_err = 0;
    bit          chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Advance one cycle and apply whatever the model says happened at that edge.
    task automatic tick();
        bit rise, clr;
        @(posedge clk);
        #1;
        psel = 1'b0;
        penable = 1'b0;
        exp_pready = 1'b0;
        exp_pslverr = 1'b0;
        exp_prdata = '{32'd0, 32'd0};
        exp_pulse = 5'd0;
        clr = 1'b0;
        rise = dsqw_done && !prev_done;
        prev_done = dsqw_done;
        if (!rst_n) begin
            m_dim = c_dim_rst; m_in = 17'd0; m_out = 17'd0;
            m_cnt = '{0, 0}; prev_done = 1'b0; pend_valid = 1'b0;
        end else begin
            if (pend_valid) begin
                case (pend_idx)
                    0: begin
                        if (pend_d[1]) exp_pulse[3] = 1'b1;
                        else if (pend_d[0]) exp_pulse[4] = 1'b1;
                    end
                    1: exp_pulse[2:0] = {pend_d[1], pend_d[2], pend_d[3]};
                    2: m_dim = '{pend_d[8:0], pend_d[8:0]};
                    3: m_in = pend_d[16:0];
                    4: m_out = pend_d[16:0];
                    5: clr = 1'b1;
                    default: ;
                endcase
                pend_valid = 1'b0;
            end
            for (int k = 0; k < 2; k++) begin
                if (clr) m_cnt[k] = rise ? 1 : 0;
                else if (rise && m_cnt[k] < c_cnt_max[k]) m_cnt[k] = m_cnt[k] + 1;
            end
        end
    endtask

    task automatic xfer(input bit wr, input logic [7:0] a, input logic [31:0] d,
                        input bit drop, input bit done_t2);
        bit          err;
        int          idx;
        logic [31:0] rd [2];
        tick();
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        tick();
        psel = 1'b1; penable = 1'b1;
        idx = int'(a[4:2]);
        err = (a[1:0] != 2'b00) || (a > 8'h14);
        if (wr && !err && !dsqw_idle) begin
            if (idx >= 2 && idx <= 4) err = 1'b1;
            if (idx == 0 && d[0] && !d[1]) err = 1'b1;
        end
        for (int k = 0; k < 2; k++) begin
            case (idx)
                1: rd[k] = {28'd0, mem_acc_err, err_size, dsqw_done, dsqw_idle};
                2: rd[k] = {23'd0, m_dim[k]};
                3: rd[k] = {15'd0, m_in};
                4: rd[k] = {15'd0, m_out};
                5: rd[k] = m_cnt[k];
                default: rd[k] = 32'd0;
            endcase
            if (wr || err) rd[k] = 32'd0;
        end
        tick();
        if (!drop) begin
            psel = 1'b1; penable = 1'b1;
            exp_pready = 1'b1;
            exp_pslverr = err;
            exp_prdata = rd;
            if (wr && !err) begin
                pend_valid = 1'b1; pend_idx = idx; pend_d = d;
            end
        end
        if (done_t2) dsqw_done = 1'b1;
        @(negedge clk);
        cap_a = apb_a.prdata; cap_b = apb_b.prdata;
        cap_err = apb_a.pslverr; cap_rdy = apb_a.pready;
    endtask

    task automatic wr32(input logic [7:0] a, input logic [31:0] d);
        xfer(1'b1, a, d, 1'b0, 1'b0);
    endtask

    task automatic rd32(input logic [7:0] a);
        xfer(1'b0, a, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic toggle_done(input int n);
        for (int i = 0; i < n; i++) begin
            tick(); dsqw_done = 1'b0;
            tick(); dsqw_done = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_pready",  32'(apb_a.pready),  32'(exp_pready));
            chk("a_pslverr", 32'(apb_a.pslverr), 32'(exp_pslverr));
            chk("a_prdata",  apb_a.prdata,       exp_prdata[0]);
            chk("a_img_dim", 32'(dim_a),         32'(m_dim[0]));
            chk("a_in_addr", 32'(in_a),          32'(m_in));
            chk("a_out_addr",32'(out_a),         32'(m_out));
            chk("a_pulses",  32'(pul_a),         32'(exp_pulse));
            chk("b_pready",  32'(apb_b.pready),  32'(exp_pready));
            chk("b_pslverr", 32'(apb_b.pslverr), 32'(exp_pslverr));
            chk("b_prdata",  apb_b.prdata,       exp_prdata[1]);
            chk("b_img_dim", 32'(dim_b),         32'(m_dim[1]));
            chk("b_in_addr", 32'(in_b),          32'(m_in));
            chk("b_out_addr",32'(out_b),         32'(m_out));
            chk("b_pulses",  32'(pul_b),         32'(exp_pulse));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    logic [7:0] addrs [11] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14,
                               8'h18, 8'h1C, 8'h06, 8'h09, 8'hFC};

    initial begin
        rst_n = 1'b0;
        tick();
        chk_en = 1'b1;
        tick(); tick();
        rst_n = 1'b1;

        // Reset values read back.
        rd32(8'h08); chk("rst_dim", cap_a, 32'd0); chk("rst_dim_b", cap_b, 32'h0A5);
        chk("rst_rdy", 32'(cap_rdy), 32'd1);
        rd32(8'h0C); chk("rst_in", cap_a, 32'd0);
        rd32(8'h10); chk("rst_out", cap_a, 32'd0);
        rd32(8'h14); chk("rst_cnt", cap_a, 32'd0);

        // Config writes and start while idle.
        wr32(8'h08, 32'h1FF);
        wr32(8'h0C, 32'h1ABCD);
        wr32(8'h00, 32'h1);
        tick(); @(negedge clk); chk("start_pulse", 32'(st_a), 32'd1);
        rd32(8'h08); chk("dim_rb", cap_a, 32'h1FF);
        rd32(8'h0C); chk("in_rb", cap_a, 32'h1ABCD);

        // Busy core: config/start rejected, soft reset accepted.
        tick(); dsqw_idle = 1'b0;
        wr32(8'h08, 32'h040); chk("busy_dim_err", 32'(cap_err), 32'd1);
        wr32(8'h00, 32'h1);   chk("busy_start_err", 32'(cap_err), 32'd1);
        rd32(8'h08); chk("dim_kept", cap_a, 32'h1FF);
        wr32(8'h00, 32'h2);
        tick(); @(negedge clk); chk("soft_pulse", 32'(pul_a), 32'b01000);
        wr32(8'h00, 32'h3); chk("both_noerr", 32'(cap_err), 32'd0);

        // Status read and selective W1C ack.
        tick(); dsqw_done = 1'b1; err_size = 1'b1;
        tick();
        rd32(8'h04); chk("status_rd", cap_a, 32'h6);
        wr32(8'h04, 32'h2);
        tick(); @(negedge clk); chk("dack_only", 32'(pul_a), 32'b00100);

        // Job counter: count, coincident clear, saturation.
        tick(); dsqw_idle = 1'b1; dsqw_done = 1'b0; err_size = 1'b0;
        wr32(8'h14, 32'h0);
        toggle_done(3);
        tick(); dsqw_done = 1'b0;
        tick();
        rd32(8'h14); chk("cnt3", cap_a, 32'd3);
        xfer(1'b1, 8'h14, 32'h0, 1'b0, 1'b1);
        rd32(8'h14); chk("cnt_clr_inc", cap_a, 32'd1);
        toggle_done(4);
        tick();
        rd32(8'h14); chk("cnt5", cap_a, 32'd5); chk("cnt_sat", cap_b, 32'd3);

        // Address errors and aborted transfer.
        rd32(8'h06); chk("mis_err", 32'(cap_err), 32'd1); chk("mis_data", cap_a, 32'd0);
        wr32(8'h18, 32'h1); chk("oor_err", 32'(cap_err), 32'd1);
        rd32(8'h18); chk("oor_data", cap_a, 32'd0);
        xfer(1'b1, 8'h08, 32'h055, 1'b1, 1'b0); chk("abort_rdy", 32'(cap_rdy), 32'd0);
        rd32(8'h08); chk("abort_kept", cap_a, 32'h1FF);

        // Randomized traffic against the model.
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                tick();
                dsqw_idle   = ($urandom_range(0, 3) != 0);
                dsqw_done   = 1'($urandom_range(0, 1));
                err_size    = 1'($urandom_range(0, 1));
                mem_acc_err = 1'($urandom_range(0, 1));
            end
            xfer(1'($urandom_range(0, 1)), addrs[$urandom_range(0, 10)], $urandom,
                 ($urandom_range(0, 9) == 0), 1'b0);
            repeat ($urandom_range(0, 2)) tick();
        end
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
